// File: rtl/gate_logic_unit.sv
// Registered bitwise AND / OR / MUX / PASS unit built from and2, or2 and mux2 cells.
// Define GATE_LOGIC_UNIT_ZFLAG_EN to add a registered zero-result flag output.

module and2 (
    input  logic a,
    input  logic b,
    output logic o
);
    assign o = a & b;
endmodule

module or2 (
    input  logic a,
    input  logic b,
    output logic o
);
    assign o = a | b;
endmodule

module mux2 (
    input  logic a,
    input  logic b,
    input  logic s,
    output logic o
);
    assign o = s ? b : a;
endmodule

module gate_logic_lane (
    input  logic [1:0] op,
    input  logic       i0,
    input  logic       i1,
    input  logic       sel,
    output logic       r
);
    logic and_o, or_o, lo_o, sel_o, hi_o;

    and2 u_and (.a(i0), .b(i1), .o(and_o));
    or2  u_or  (.a(i0), .b(i1), .o(or_o));
    mux2 u_lo  (.a(and_o), .b(or_o), .s(op[0]), .o(lo_o));

    // op[1] side: per-bit select (op=10) or straight pass of i0 (op=11)
    mux2 u_sel (.a(i0), .b(i1), .s(sel), .o(sel_o));
    mux2 u_hi  (.a(sel_o), .b(i0), .s(op[0]), .o(hi_o));

    mux2 u_out (.a(lo_o), .b(hi_o), .s(op[1]), .o(r));
endmodule

module gate_logic_unit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       op,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] sel,
    output logic [WIDTH-1:0] o,
    output logic             out_valid
`ifdef GATE_LOGIC_UNIT_ZFLAG_EN
    ,
    output logic             zero
`endif
);
    logic [WIDTH-1:0] res;

    for (genvar k = 0; k < WIDTH; k++) begin : g_lane
        gate_logic_lane u_lane (
            .op (op),
            .i0 (i0[k]),
            .i1 (i1[k]),
            .sel(sel[k]),
            .r  (res[k])
        );
    end

    // o only loads under in_valid, so junk on idle operands never reaches it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o         <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) o <= res;
        end
    end

`ifdef GATE_LOGIC_UNIT_ZFLAG_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)        zero <= 1'b0;
        else if (in_valid) zero <= (res == '0);
    end
`endif
endmodule

// File: tb/tb_gate_logic_unit.sv
// Self-checking bench for gate_logic_unit: directed cases plus random ops against a behavioural model.
module tb_gate_logic_unit;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [1:0]   op = 2'b00;
    logic         in_valid = 1'b0;
    logic [W-1:0] i0 = '0, i1 = '0, sel = '0;
    logic [W-1:0] o;
    logic         out_valid;
`ifdef GATE_LOGIC_UNIT_ZFLAG_EN
    logic         zero;
    logic         exp_z = 1'b0;
`endif

    int passes = 0;
    int checks = 0;
    logic [W-1:0] exp_o = '0;
    logic         exp_v = 1'b0;

    gate_logic_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .op(op), .in_valid(in_valid),
        .i0(i0), .i1(i1), .sel(sel), .o(o), .out_valid(out_valid)
`ifdef GATE_LOGIC_UNIT_ZFLAG_EN
        , .zero(zero)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] model(input logic [1:0] f, input logic [W-1:0] a,
                                           input logic [W-1:0] b, input logic [W-1:0] s);
        logic [W-1:0] r;
        r = '0;
        case (f)
            2'd0: r = a & b;
            2'd1: r = a | b;
            2'd2: for (int k = 0; k < W; k++) r[k] = s[k] ? b[k] : a[k];
            default: r = a;
        endcase
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // drive one cycle, advance the model on the edge, check just after it
    task automatic step(input string tag, input logic [1:0] f, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] s, input logic v);
        op = f; i0 = a; i1 = b; sel = s; in_valid = v;
        @(posedge clk);
        if (reset) begin
            exp_v = v;
            if (v) begin
                exp_o = model(f, a, b, s);
`ifdef GATE_LOGIC_UNIT_ZFLAG_EN
                exp_z = (exp_o == '0);
`endif
            end
        end
        #1;
        check({tag, "_o"}, 64'(o), 64'(exp_o));
        check({tag, "_v"}, 64'(out_valid), 64'(exp_v));
    endtask

    logic [W-1:0] pa [4] = '{16'h0000, 16'haa55, 16'hffff, 16'h0001};
    logic [W-1:0] pb [4] = '{16'h0000, 16'h55aa, 16'h0001, 16'h7fff};

    initial begin
        // reset held with in_valid toggling: outputs stay cleared
        #1;
        check("rst_init_o", 64'(o), 64'(0));
        check("rst_init_v", 64'(out_valid), 64'(0));
        for (int c = 0; c < 4; c++)
            step("rst_hold", 2'b01, 16'hffff, 16'h1234, 16'h0, c[0]);
        reset = 1'b1;
        step("post_rst_idle", 2'b01, 16'hffff, 16'h0, 16'h0, 1'b0);
        step("first_cap", 2'b01, 16'h00f0, 16'h0f00, 16'h0, 1'b1);
        check("first_cap_val", 64'(o), 64'(16'h0ff0));

        // AND then OR pairs, back-to-back
        for (int p = 0; p < 4; p++) step("and", 2'b00, pa[p], pb[p], 16'h0, 1'b1);
        for (int p = 0; p < 4; p++) step("or", 2'b01, pa[p], pb[p], 16'h0, 1'b1);
        step("mux_ff00", 2'b10, 16'haa55, 16'h55aa, 16'hff00, 1'b1);
        check("mux_ff00_val", 64'(o), 64'(16'h5555));
        step("mux_0000", 2'b10, 16'haa55, 16'h55aa, 16'h0000, 1'b1);
        check("mux_0000_val", 64'(o), 64'(16'haa55));
        step("pass", 2'b11, 16'h1234, 16'hffff, 16'h0, 1'b1);
        check("pass_val", 64'(o), 64'(16'h1234));

`ifdef GATE_LOGIC_UNIT_ZFLAG_EN
        step("z_and", 2'b00, 16'haa55, 16'h55aa, 16'h0, 1'b1);
        check("zero_and", 64'(zero), 64'(1));
        step("z_or", 2'b01, 16'haa55, 16'h55aa, 16'h0, 1'b1);
        check("zero_or", 64'(zero), 64'(0));
`endif

        // random ops with random valid gaps
        for (int n = 0; n < 300; n++)
            step("rand", 2'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                 ($urandom_range(0, 3) != 0));

        // valid gap: result held while inputs churn
        step("gap_load", 2'b01, 16'haa55, 16'h55aa, 16'h0, 1'b1);
        check("gap_load_val", 64'(o), 64'(16'hffff));
        for (int c = 0; c < 3; c++) begin
            step("gap_idle", 2'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 1'b0);
            check("gap_hold_val", 64'(o), 64'(16'hffff));
        end

        // async reset between edges with an operation in flight
        op = 2'b01; i0 = 16'h1111; i1 = 16'h2222; in_valid = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_o", 64'(o), 64'(0));
        check("async_rst_v", 64'(out_valid), 64'(0));
`ifdef GATE_LOGIC_UNIT_ZFLAG_EN
        check("async_rst_z", 64'(zero), 64'(0));
`endif
        @(posedge clk); #1;
        check("rst_edge_o", 64'(o), 64'(0));
        check("rst_edge_v", 64'(out_valid), 64'(0));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1);
    end
endmodule
